uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, meaning clocks per serial bit period; legal range 4..1023.
REQ-002 Parameter NUM_DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 clk  input  1  system clock; all state updates on the rising edge; one clock only.
REQ-004 n_rst  input  1  reset; synchronous and active-low.
REQ-005 serial_in  input  1  asynchronous serial line; idles high.
REQ-006 data_read  input  1  consumer pulse acknowledging rx_data.
REQ-007 rx_data  output  NUM_DATA_BITS  last good frame payload, LSB received first.
REQ-008 data_ready  output  1  rx_data holds an unread frame.
REQ-009 overrun_error  output  1  a frame overwrote unread data.
REQ-010 framing_error  output  1  the last frame had a low stop bit.

Function
REQ-011 serial_in SHALL pass through a 2-flop synchroniser; "line" below means the synchroniser output.
REQ-012 A start event SHALL be a line 1->0 transition seen in IDLE; transitions in any other state are ignored.
REQ-013 The FSM SHALL have the states IDLE, START_CHK, RECV, STOP_CHK and LOAD.
REQ-014 Let t be the start-event cycle, H = floor(CLKS_PER_BIT/2) and P = CLKS_PER_BIT.
REQ-015 START_CHK SHALL sample the line at t+H; if it is high (false start), the FSM returns to IDLE with no output change.
REQ-016 RECV SHALL sample data bit k (k=0..NUM_DATA_BITS-1) at t+H+(k+1)*P and shift it in LSB-first.
REQ-017 STOP_CHK SHALL sample the stop bit at t+H+(NUM_DATA_BITS+1)*P.
REQ-018 If the stop bit is 1, the FSM SHALL enter LOAD; in the next cycle rx_data is updated, data_ready=1, framing_error=0, and the FSM returns to IDLE.
REQ-019 If the stop bit is 0, framing_error SHALL be set to 1 one cycle after the sample; rx_data, data_ready and overrun_error SHALL be unchanged; the FSM returns to IDLE.
REQ-020 A new frame SHALL be detectable no earlier than the cycle after the FSM returns to IDLE.
REQ-021 A LOAD while data_ready=1 and data_read=0 SHALL set overrun_error=1, and the new payload SHALL overwrite rx_data.
REQ-022 A LOAD coinciding with data_read=1 SHALL leave data_ready=1 and SHALL NOT set overrun_error.
REQ-023 data_read=1 outside LOAD SHALL clear data_ready and overrun_error at the next edge.
REQ-024 data_read=1 while data_ready=0 SHALL have no effect.
REQ-025 framing_error SHALL hold until the next successful LOAD or reset.
REQ-026 The bit-period counter SHALL clear on every sample point and never exceed P-1.
REQ-027 The block SHALL have no wrap-around ambiguity at the maximum CLKS_PER_BIT.

Reset
REQ-028 While n_rst=0 at a clock edge, the next state SHALL be:
- FSM in IDLE;
- counter = 0;
- shift register = all-ones;
- both synchroniser flops = 1;
- rx_data = 0, data_ready = 0, overrun_error = 0, framing_error = 0.
REQ-029 A reset asserted mid-frame SHALL abandon the frame with no partial load.
REQ-030 After reset release, a frame SHALL be accepted only after a fresh 1->0 transition.

Structure
REQ-031 The shared package uart_rx_pkg SHALL hold the FSM state enum and the default constants for CLKS_PER_BIT and NUM_DATA_BITS.
REQ-032 Bit timing SHALL be a sub-module rx_bit_timer: parameterised width, synchronous clear, enable, and a one-cycle terminal-count strobe at a programmable value.
REQ-033 The FSM, shift register and output registers SHALL reside in uart_rx_ctrl.

Verification (CLKS_PER_BIT=10, NUM_DATA_BITS=8)
REQ-034 Good frame 0xA5, then data_read -> data_ready=1, rx_data=0xA5 at t+H+9P+1; cleared 1 cycle after data_read.
REQ-035 Low pulse of 3 clocks -> false start at t+5; data_ready, framing_error and rx_data unchanged; IDLE.
REQ-036 Frame 0x3C with stop=0 -> framing_error=1, rx_data keeps the prior value, data_ready unchanged; next good frame 0x11 clears framing_error.
REQ-037 Frames 0x01 then 0x02 with no data_read -> overrun_error=1, rx_data=0x02; data_read clears both flags.
REQ-038 Second LOAD coinciding with data_read -> data_ready=1, overrun_error=0, rx_data updated.
REQ-039 n_rst=0 during data bit 4 of a frame, released 2 cycles later -> all outputs 0; next good frame 0x7E loads correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and default constants for the UART receive controller.
package uart_rx_pkg;

  localparam int DEF_CLKS_PER_BIT  = 10;
  localparam int DEF_NUM_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    RECV      = 3'd2,
    STOP_CHK  = 3'd3,
    LOAD      = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter: counts while enabled, strobes tc_o for one cycle when it
// reaches tc_val_i. The owner clears it on every strobe so it never wraps.
module rx_bit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == tc_val_i);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchroniser, frame FSM, LSB-first shift register and the
// consumer-facing data/status registers.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int NUM_DATA_BITS = DEF_NUM_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     serial_in,
  input  logic                     data_read,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     data_ready,
  output logic                     overrun_error,
  output logic                     framing_error,
  output rx_state_e                dbg_state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(NUM_DATA_BITS);
  localparam logic [CW-1:0] TC_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TC_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(NUM_DATA_BITS - 1);

  rx_state_e                state_q, state_d;
  logic                     sync1_q, sync2_q, line_prev_q;
  logic [IW-1:0]            bit_idx_q, bit_idx_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
  logic [NUM_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                     data_ready_q, data_ready_d;
  logic                     overrun_q, overrun_d;
  logic                     framing_q, framing_d;
  logic                     line;
  logic                     tmr_en, tmr_clr, tmr_tc;
  logic [CW-1:0]            tmr_tc_val;

  assign line = sync2_q;

  // Counter runs only while a frame is in progress and restarts at each sample point.
  assign tmr_en  = (state_q != IDLE) && (state_q != LOAD);
  assign tmr_clr = !tmr_en || tmr_tc;

  rx_bit_timer #(.W(CW)) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;
    tmr_tc_val   = TC_FULL;

    if (data_read && data_ready_q) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (line_prev_q && !line) state_d = START_CHK;
      end
      START_CHK: begin
        tmr_tc_val = TC_HALF;
        bit_idx_d  = '0;
        if (tmr_tc) state_d = line ? IDLE : RECV;
      end
      RECV: begin
        if (tmr_tc) begin
          shift_d = {line, shift_q[NUM_DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) state_d = STOP_CHK;
          else bit_idx_d = bit_idx_q + IW'(1);
        end
      end
      STOP_CHK: begin
        if (tmr_tc) begin
          if (line) begin
            state_d = LOAD;
          end else begin
            framing_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      LOAD: begin
        // A read landing on the load cycle consumes the old word, so no overrun.
        rx_data_d    = shift_q;
        data_ready_d = 1'b1;
        framing_d    = 1'b0;
        if (data_read) overrun_d = 1'b0;
        else if (data_ready_q) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      line_prev_q  <= 1'b1;
      bit_idx_q    <= '0;
      shift_q      <= '1;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= serial_in;
      sync2_q      <= sync1_q;
      line_prev_q  <= sync2_q;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      framing_q    <= framing_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at CLKS_PER_BIT=10, NUM_DATA_BITS=8.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int P = 10;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         serial_in;
  logic         data_read;
  logic [N-1:0] rx_data;
  logic         data_ready;
  logic         overrun_error;
  logic         framing_error;
  rx_state_e    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_ctrl #(.CLKS_PER_BIT(P), .NUM_DATA_BITS(N)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
  endtask

  // Full frame; optionally hold data_read high during the LOAD cycle (edge 98..99).
  task automatic send_frame(input logic [N-1:0] data, input logic stop, input logic rd_in_load);
    serial_in = 1'b0;
    tick(P);
    for (int i = 0; i < N; i++) begin
      serial_in = data[i];
      tick(P);
    end
    serial_in = stop;
    tick(P - 2);
    if (rd_in_load) data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
    tick(1);
    serial_in = 1'b1;
    tick(4);
  endtask

  task automatic chk_outputs(input string tag, input logic [N-1:0] d, input logic dr,
                             input logic ov, input logic fe);
    chk({tag, ".rx_data"}, 32'(rx_data), 32'(d));
    chk({tag, ".data_ready"}, 32'(data_ready), 32'(dr));
    chk({tag, ".overrun"}, 32'(overrun_error), 32'(ov));
    chk({tag, ".framing"}, 32'(framing_error), 32'(fe));
  endtask

  initial begin
    logic [N-1:0] a5;
    a5 = 8'hA5;
    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    tick(3);
    n_rst = 1'b1;
    tick(2);
    chk_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.state", 32'(dbg_state), 32'(IDLE));

    // Good frame 0xA5 with exact load timing.
    serial_in = 1'b0;
    tick(P);
    for (int i = 0; i < N; i++) begin
      serial_in = a5[i];
      tick(P);
    end
    serial_in = 1'b1;
    tick(8);
    chk("a5.ready_before_load", 32'(data_ready), 32'd0);
    tick(1);
    chk_outputs("a5.loaded", 8'hA5, 1'b1, 1'b0, 1'b0);
    tick(5);
    read_pulse();
    chk_outputs("a5.after_read", 8'hA5, 1'b0, 1'b0, 1'b0);
    read_pulse();
    chk_outputs("read_when_empty", 8'hA5, 1'b0, 1'b0, 1'b0);

    // False start: 3-clock low glitch.
    tick(2);
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    chk("glitch.state_start_chk", 32'(dbg_state), 32'(START_CHK));
    tick(5);
    chk("glitch.state_idle", 32'(dbg_state), 32'(IDLE));
    chk_outputs("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);
    tick(4);

    // Framing error, then a good frame clears it.
    send_frame(8'h3C, 1'b0, 1'b0);
    chk_outputs("framing", 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("framing.state", 32'(dbg_state), 32'(IDLE));
    send_frame(8'h11, 1'b1, 1'b0);
    chk_outputs("after_framing", 8'h11, 1'b1, 1'b0, 1'b0);
    read_pulse();

    // Overrun: two frames with no read in between.
    send_frame(8'h01, 1'b1, 1'b0);
    chk_outputs("ovr.first", 8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    chk_outputs("ovr.second", 8'h02, 1'b1, 1'b1, 1'b0);
    read_pulse();
    chk_outputs("ovr.cleared", 8'h02, 1'b0, 1'b0, 1'b0);

    // Read coinciding with a LOAD while data is pending.
    send_frame(8'h55, 1'b1, 1'b0);
    chk_outputs("rdload.first", 8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'h66, 1'b1, 1'b1);
    chk_outputs("rdload.second", 8'h66, 1'b1, 1'b0, 1'b0);

    // Reset during data bit 4 of frame 0xF3; remaining bits are all high.
    serial_in = 1'b0;
    tick(P);
    for (int i = 0; i < 4; i++) begin
      serial_in = (i < 2) ? 1'b1 : 1'b0;
      tick(P);
    end
    serial_in = 1'b1;
    tick(5);
    n_rst = 1'b0;
    tick(2);
    n_rst = 1'b1;
    chk_outputs("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("midreset.state", 32'(dbg_state), 32'(IDLE));
    tick(3 + 4 * P + 4);
    chk_outputs("midreset.no_partial", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("midreset.still_idle", 32'(dbg_state), 32'(IDLE));
    send_frame(8'h7E, 1'b1, 1'b0);
    chk_outputs("post_reset", 8'h7E, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
